// File: rtl/rx_char_fifo.sv
// Receive character FIFO: edge-detected write strobe, first-word-fall-through
// read port, registered status and sticky overrun/underflow flags.
module rx_char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     char_received,
    input  logic [WIDTH-1:0]         output_bus,
    input  logic                     rd_en,
    input  logic                     clr_flags,
    output logic [WIDTH-1:0]         data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic [WIDTH-1:0] r_dout;
    logic             r_char_q;
    logic             r_overrun;
    logic             r_underflow;

    logic             w_wr_stb;
    logic             w_do_wr;
    logic             w_do_rd;
    logic [AW-1:0]    w_wr_ptr_nxt;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             w_ovr_set;
    logic             w_udf_set;

    assign w_wr_stb = char_received & ~r_char_q;
    // A full FIFO still accepts a write when a pop frees the slot this cycle.
    assign w_do_wr  = w_wr_stb & (~r_full | rd_en);
    assign w_do_rd  = rd_en & ~r_empty;

    assign w_wr_ptr_nxt = r_wr_ptr + AW'(w_do_wr);
    assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_do_rd);
    assign w_count_nxt  = r_count + CW'(w_do_wr) - CW'(w_do_rd);

    assign w_ovr_set = w_wr_stb & r_full & ~rd_en;
    assign w_udf_set = rd_en & r_empty;

    // Next head: bypass the incoming character when it lands at the new head.
    always_comb begin
        w_dout_nxt = r_dout;
        if (w_count_nxt != '0) begin
            if (w_do_wr && (w_rd_ptr_nxt == r_wr_ptr)) begin
                w_dout_nxt = output_bus;
            end else begin
                w_dout_nxt = r_mem[w_rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= output_bus;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_dout      <= '0;
            r_char_q    <= 1'b0;
            r_overrun   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_empty     <= (w_count_nxt == '0);
            r_full      <= (w_count_nxt == FULL_CNT);
            r_dout      <= w_dout_nxt;
            r_char_q    <= char_received;
            r_overrun   <= w_ovr_set | (r_overrun & ~clr_flags);
            r_underflow <= w_udf_set | (r_underflow & ~clr_flags);
        end
    end

    assign data_out  = r_dout;
    assign empty     = r_empty;
    assign full      = r_full;
    assign count     = r_count;
    assign overrun   = r_overrun;
    assign underflow = r_underflow;
endmodule
